// File: rtl/axi4lite_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : axi4lite_mem_bridge
//  Description : AXI4-Lite responder bridging a core's AXI4-Lite master port
//                onto a simple strobe/response main-memory bus. One
//                transaction in flight at a time, writes win over reads on
//                simultaneous arrival.
//  Ports       : clk, reset (async, active-high)
//                AXI4-Lite slave: s_aw*, s_w*, s_b*, s_ar*, s_r*
//                Memory bus     : mem_read, mem_write, mem_address,
//                                 mem_write_data, mem_write_strobe,
//                                 mem_read_data, mem_response
//  Options     : `define MEM_TIMEOUT_EN to abandon a memory request after
//                TIMEOUT_CYCLES cycles and answer it with SLVERR.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4lite_mem_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    // write address
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [2:0]              s_awprot,
    // write data
    input  logic                    s_wvalid,
    output logic                    s_wready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    // write response
    output logic                    s_bvalid,
    input  logic                    s_bready,
    output logic [1:0]              s_bresp,
    // read address
    input  logic                    s_arvalid,
    output logic                    s_arready,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic [2:0]              s_arprot,
    // read data
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    // memory bus
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH-1:0]   mem_write_data,
    output logic [DATA_WIDTH/8-1:0] mem_write_strobe,
    input  logic [DATA_WIDTH-1:0]   mem_read_data,
    input  logic                    mem_response
);

    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MEM_WR = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_B_RESP = 3'd3,
        ST_R_RESP = 3'd4
    } state_t;

    state_t                  state_q,            state_d;
    logic                    aw_cap_q,           aw_cap_d;
    logic                    w_cap_q,            w_cap_d;
    logic                    mem_read_q,         mem_read_d;
    logic                    mem_write_q,        mem_write_d;
    logic [ADDR_WIDTH-1:0]   mem_address_q,      mem_address_d;
    logic [DATA_WIDTH-1:0]   mem_write_data_q,   mem_write_data_d;
    logic [DATA_WIDTH/8-1:0] mem_write_strobe_q, mem_write_strobe_d;
    logic                    s_bvalid_q,         s_bvalid_d;
    logic [1:0]              s_bresp_q,          s_bresp_d;
    logic                    s_rvalid_q,         s_rvalid_d;
    logic [DATA_WIDTH-1:0]   s_rdata_q,          s_rdata_d;
    logic [1:0]              s_rresp_q,          s_rresp_d;

`ifdef MEM_TIMEOUT_EN
    localparam int                 c_cnt_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
    logic [c_cnt_w-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // Protection bits carry no meaning for this memory.
    logic w_unused_prot;
    assign w_unused_prot = ^{s_awprot, s_arprot};

    // Readies are combinational so a write arriving in the same cycle as a
    // read can block the read; they are forced low while reset is asserted.
    logic w_idle;
    logic w_aw_hs, w_w_hs, w_ar_hs;

    assign w_idle    = (state_q == ST_IDLE) && !reset;
    assign s_awready = w_idle && !aw_cap_q;
    assign s_wready  = w_idle && !w_cap_q;
    assign s_arready = w_idle && !aw_cap_q && !w_cap_q && !s_awvalid && !s_wvalid;

    assign w_aw_hs = s_awvalid && s_awready;
    assign w_w_hs  = s_wvalid  && s_wready;
    assign w_ar_hs = s_arvalid && s_arready;

    always_comb begin
        state_d            = state_q;
        aw_cap_d           = aw_cap_q;
        w_cap_d            = w_cap_q;
        mem_read_d         = mem_read_q;
        mem_write_d        = mem_write_q;
        mem_address_d      = mem_address_q;
        mem_write_data_d   = mem_write_data_q;
        mem_write_strobe_d = mem_write_strobe_q;
        s_bvalid_d         = s_bvalid_q;
        s_bresp_d          = s_bresp_q;
        s_rvalid_d         = s_rvalid_q;
        s_rdata_d          = s_rdata_q;
        s_rresp_d          = s_rresp_q;
`ifdef MEM_TIMEOUT_EN
        tmo_cnt_d          = tmo_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                aw_cap_d = aw_cap_q | w_aw_hs;
                w_cap_d  = w_cap_q  | w_w_hs;
                if (w_aw_hs) begin
                    mem_address_d = s_awaddr;
                end
                if (w_w_hs) begin
                    mem_write_data_d   = s_wdata;
                    mem_write_strobe_d = s_wstrb;
                end
                if (aw_cap_d && w_cap_d) begin
                    state_d     = ST_MEM_WR;
                    mem_write_d = 1'b1;
                    aw_cap_d    = 1'b0;
                    w_cap_d     = 1'b0;
`ifdef MEM_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                end else if (w_ar_hs) begin
                    state_d       = ST_MEM_RD;
                    mem_read_d    = 1'b1;
                    mem_address_d = s_araddr;
`ifdef MEM_TIMEOUT_EN
                    tmo_cnt_d     = '0;
`endif
                end
            end

            ST_MEM_WR: begin
                // A response on the timeout cycle is checked first and wins.
                if (mem_response) begin
                    mem_write_d = 1'b0;
                    s_bvalid_d  = 1'b1;
                    s_bresp_d   = c_resp_okay;
                    state_d     = ST_B_RESP;
                end
`ifdef MEM_TIMEOUT_EN
                else if (tmo_cnt_q == c_tmo_last) begin
                    mem_write_d = 1'b0;
                    s_bvalid_d  = 1'b1;
                    s_bresp_d   = c_resp_slverr;
                    state_d     = ST_B_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + c_cnt_w'(1);
                end
`endif
            end

            ST_MEM_RD: begin
                if (mem_response) begin
                    mem_read_d = 1'b0;
                    s_rvalid_d = 1'b1;
                    s_rdata_d  = mem_read_data;
                    s_rresp_d  = c_resp_okay;
                    state_d    = ST_R_RESP;
                end
`ifdef MEM_TIMEOUT_EN
                else if (tmo_cnt_q == c_tmo_last) begin
                    mem_read_d = 1'b0;
                    s_rvalid_d = 1'b1;
                    s_rdata_d  = '0;
                    s_rresp_d  = c_resp_slverr;
                    state_d    = ST_R_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + c_cnt_w'(1);
                end
`endif
            end

            ST_B_RESP: begin
                if (s_bready) begin
                    s_bvalid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end

            ST_R_RESP: begin
                if (s_rready) begin
                    s_rvalid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                s_bvalid_d  = 1'b0;
                s_rvalid_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= ST_IDLE;
            aw_cap_q           <= 1'b0;
            w_cap_q            <= 1'b0;
            mem_read_q         <= 1'b0;
            mem_write_q        <= 1'b0;
            mem_address_q      <= '0;
            mem_write_data_q   <= '0;
            mem_write_strobe_q <= '0;
            s_bvalid_q         <= 1'b0;
            s_bresp_q          <= 2'b00;
            s_rvalid_q         <= 1'b0;
            s_rdata_q          <= '0;
            s_rresp_q          <= 2'b00;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_q          <= '0;
`endif
        end else begin
            state_q            <= state_d;
            aw_cap_q           <= aw_cap_d;
            w_cap_q            <= w_cap_d;
            mem_read_q         <= mem_read_d;
            mem_write_q        <= mem_write_d;
            mem_address_q      <= mem_address_d;
            mem_write_data_q   <= mem_write_data_d;
            mem_write_strobe_q <= mem_write_strobe_d;
            s_bvalid_q         <= s_bvalid_d;
            s_bresp_q          <= s_bresp_d;
            s_rvalid_q         <= s_rvalid_d;
            s_rdata_q          <= s_rdata_d;
            s_rresp_q          <= s_rresp_d;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_q          <= tmo_cnt_d;
`endif
        end
    end

    assign mem_read         = mem_read_q;
    assign mem_write        = mem_write_q;
    assign mem_address      = mem_address_q;
    assign mem_write_data   = mem_write_data_q;
    assign mem_write_strobe = mem_write_strobe_q;
    assign s_bvalid         = s_bvalid_q;
    assign s_bresp          = s_bresp_q;
    assign s_rvalid         = s_rvalid_q;
    assign s_rdata          = s_rdata_q;
    assign s_rresp          = s_rresp_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4lite_mem_bridge
//  Description : Directed self-checking bench for axi4lite_mem_bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4lite_mem_bridge;

    logic        clk;
    logic        reset;
    logic        s_awvalid, s_awready;
    logic [31:0] s_awaddr;
    logic [2:0]  s_awprot;
    logic        s_wvalid, s_wready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_bvalid, s_bready;
    logic [1:0]  s_bresp;
    logic        s_arvalid, s_arready;
    logic [31:0] s_araddr;
    logic [2:0]  s_arprot;
    logic        s_rvalid, s_rready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic [3:0]  mem_write_strobe;
    logic        mem_response;

    int n_checks = 0;
    int n_errors = 0;

    axi4lite_mem_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .s_awvalid        (s_awvalid),
        .s_awready        (s_awready),
        .s_awaddr         (s_awaddr),
        .s_awprot         (s_awprot),
        .s_wvalid         (s_wvalid),
        .s_wready         (s_wready),
        .s_wdata          (s_wdata),
        .s_wstrb          (s_wstrb),
        .s_bvalid         (s_bvalid),
        .s_bready         (s_bready),
        .s_bresp          (s_bresp),
        .s_arvalid        (s_arvalid),
        .s_arready        (s_arready),
        .s_araddr         (s_araddr),
        .s_arprot         (s_arprot),
        .s_rvalid         (s_rvalid),
        .s_rready         (s_rready),
        .s_rdata          (s_rdata),
        .s_rresp          (s_rresp),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_strobe (mem_write_strobe),
        .mem_read_data    (mem_read_data),
        .mem_response     (mem_response)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The memory strobes must never be asserted together.
    always @(negedge clk) begin
        if (mem_read && mem_write) check("rd_wr_exclusive", 32'd1, 32'd0);
    end

    initial begin
        int n;
        reset = 1'b1;
        s_awvalid = 0; s_awaddr = 0; s_awprot = 3'b111;
        s_wvalid = 0;  s_wdata = 0;  s_wstrb = 0;
        s_bready = 0;
        s_arvalid = 0; s_araddr = 0; s_arprot = 3'b101;
        s_rready = 0;
        mem_read_data = 32'hDEADBEEF; mem_response = 0;

        // ---- reset state ----
        tick(); tick();
        check("rst_awready", {31'd0, s_awready}, 0);
        check("rst_arready", {31'd0, s_arready}, 0);
        check("rst_mem_write", {31'd0, mem_write}, 0);
        check("rst_mem_addr", mem_address, 0);
        check("rst_bvalid", {31'd0, s_bvalid}, 0);
        check("rst_rdata", s_rdata, 0);
        reset = 1'b0;
        #1;
        check("idle_awready", {31'd0, s_awready}, 1);
        check("idle_wready", {31'd0, s_wready}, 1);
        check("idle_arready", {31'd0, s_arready}, 1);

        // ---- 1: AW+W same cycle, response on the third request cycle ----
        s_awvalid = 1; s_awaddr = 32'h10; s_wvalid = 1; s_wdata = 32'hCAFEBABE; s_wstrb = 4'hF;
        tick();
        s_awvalid = 0; s_wvalid = 0;
        check("t1_awready_busy", {31'd0, s_awready}, 0);
        for (int i = 0; i < 3; i++) begin
            check("t1_mem_write", {31'd0, mem_write}, 1);
            check("t1_mem_addr", mem_address, 32'h10);
            check("t1_mem_wdata", mem_write_data, 32'hCAFEBABE);
            check("t1_mem_strb", {28'd0, mem_write_strobe}, 32'hF);
            if (i == 2) mem_response = 1;
            tick();
        end
        mem_response = 0;
        check("t1_mem_write_done", {31'd0, mem_write}, 0);
        check("t1_bvalid", {31'd0, s_bvalid}, 1);
        check("t1_bresp", {30'd0, s_bresp}, 0);
        tick();
        check("t1_bvalid_held", {31'd0, s_bvalid}, 1);
        s_bready = 1;
        tick();
        s_bready = 0;
        check("t1_bvalid_clr", {31'd0, s_bvalid}, 0);
        check("t1_back_idle", {31'd0, s_awready}, 1);

        // ---- 2: W two cycles before AW ----
        s_wvalid = 1; s_wdata = 32'h0BADF00D; s_wstrb = 4'h3;
        tick();
        s_wvalid = 0;
        check("t2_wready_drop", {31'd0, s_wready}, 0);
        check("t2_awready", {31'd0, s_awready}, 1);
        check("t2_arready_blk", {31'd0, s_arready}, 0);
        check("t2_no_write1", {31'd0, mem_write}, 0);
        tick();
        check("t2_no_write2", {31'd0, mem_write}, 0);
        s_awvalid = 1; s_awaddr = 32'h14;
        tick();
        s_awvalid = 0;
        check("t2_mem_write", {31'd0, mem_write}, 1);
        check("t2_mem_addr", mem_address, 32'h14);
        check("t2_mem_wdata", mem_write_data, 32'h0BADF00D);
        check("t2_mem_strb", {28'd0, mem_write_strobe}, 32'h3);
        mem_response = 1;
        tick();
        mem_response = 0;
        check("t2_bvalid", {31'd0, s_bvalid}, 1);
        check("t2_bresp", {30'd0, s_bresp}, 0);
        s_bready = 1;
        tick();
        s_bready = 0;
        check("t2_bvalid_clr", {31'd0, s_bvalid}, 0);

        // ---- 3: read 0x20 with slow s_rready ----
        s_arvalid = 1; s_araddr = 32'h20;
        #1;
        check("t3_arready", {31'd0, s_arready}, 1);
        tick();
        s_arvalid = 0;
        check("t3_mem_read", {31'd0, mem_read}, 1);
        check("t3_mem_addr", mem_address, 32'h20);
        check("t3_arready_busy", {31'd0, s_arready}, 0);
        check("t3_rvalid_early", {31'd0, s_rvalid}, 0);
        tick();
        mem_response = 1; mem_read_data = 32'h12345678;
        tick();
        mem_response = 0; mem_read_data = 32'hDEADDEAD;
        check("t3_mem_read_done", {31'd0, mem_read}, 0);
        for (int i = 0; i < 4; i++) begin
            check("t3_rvalid", {31'd0, s_rvalid}, 1);
            check("t3_rdata", s_rdata, 32'h12345678);
            check("t3_rresp", {30'd0, s_rresp}, 0);
            tick();
        end
        s_rready = 1;
        tick();
        s_rready = 0;
        check("t3_rvalid_clr", {31'd0, s_rvalid}, 0);

        // ---- 4: write and read arrive together, write goes first ----
        s_awvalid = 1; s_awaddr = 32'h30; s_wvalid = 1; s_wdata = 32'h55AA55AA; s_wstrb = 4'hC;
        s_arvalid = 1; s_araddr = 32'h34;
        #1;
        check("t4_arready_blk", {31'd0, s_arready}, 0);
        tick();
        s_awvalid = 0; s_wvalid = 0;
        check("t4_mem_write", {31'd0, mem_write}, 1);
        check("t4_mem_read", {31'd0, mem_read}, 0);
        check("t4_mem_addr", mem_address, 32'h30);
        mem_response = 1;
        tick();
        mem_response = 0;
        check("t4_bvalid", {31'd0, s_bvalid}, 1);
        check("t4_arready_bresp", {31'd0, s_arready}, 0);
        s_bready = 1;
        tick();
        s_bready = 0;
        check("t4_arready_after", {31'd0, s_arready}, 1);
        tick();
        s_arvalid = 0;
        check("t4_rd_mem_read", {31'd0, mem_read}, 1);
        check("t4_rd_mem_addr", mem_address, 32'h34);
        mem_response = 1; mem_read_data = 32'hA5A5F00F;
        tick();
        mem_response = 0;
        check("t4_rdata", s_rdata, 32'hA5A5F00F);
        s_rready = 1;
        tick();
        s_rready = 0;

        // ---- stray response in IDLE is ignored ----
        mem_response = 1;
        tick();
        mem_response = 0;
        check("stray_bvalid", {31'd0, s_bvalid}, 0);
        check("stray_rvalid", {31'd0, s_rvalid}, 0);

        // ---- 5: reset during a read ----
        s_arvalid = 1; s_araddr = 32'h38;
        tick();
        s_arvalid = 0;
        check("t5_mem_read", {31'd0, mem_read}, 1);
        #2 reset = 1;
        #1;
        check("t5_rst_mem_read", {31'd0, mem_read}, 0);
        check("t5_rst_addr", mem_address, 0);
        check("t5_rst_arready", {31'd0, s_arready}, 0);
        check("t5_rst_rdata", s_rdata, 0);
        tick();
        reset = 0;
        s_arvalid = 1; s_araddr = 32'h40;
        tick();
        s_arvalid = 0;
        check("t5_mem_read2", {31'd0, mem_read}, 1);
        check("t5_mem_addr2", mem_address, 32'h40);
        mem_response = 1; mem_read_data = 32'h40404040;
        tick();
        mem_response = 0;
        check("t5_rvalid", {31'd0, s_rvalid}, 1);
        check("t5_rdata", s_rdata, 32'h40404040);
        check("t5_rresp", {30'd0, s_rresp}, 0);
        s_rready = 1;
        tick();
        s_rready = 0;

        // ---- 6: memory never answers ----
        mem_read_data = 32'hFFFFFFFF;
        s_arvalid = 1; s_araddr = 32'h50;
        tick();
        s_arvalid = 0;
        n = 0;
        while (mem_read && n < 40) begin
            n++;
            tick();
        end
`ifdef MEM_TIMEOUT_EN
        check("t6_read_cycles", n, 8);
        check("t6_rvalid", {31'd0, s_rvalid}, 1);
        check("t6_rresp", {30'd0, s_rresp}, 32'h2);
        check("t6_rdata", s_rdata, 0);
        s_rready = 1;
        tick();
        s_rready = 0;
        check("t6_rvalid_clr", {31'd0, s_rvalid}, 0);
`else
        check("t6_read_cycles", n, 40);
        check("t6_rvalid_none", {31'd0, s_rvalid}, 0);
        mem_response = 1; mem_read_data = 32'h66666666;
        tick();
        mem_response = 0;
        check("t6_rdata", s_rdata, 32'h66666666);
        check("t6_rresp", {30'd0, s_rresp}, 0);
        s_rready = 1;
        tick();
        s_rready = 0;
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
